// File: rtl/gpio_input_conditioner_if.sv
// Board-input conditioner bundle: raw pins in, debounced level plus edge strobes out.
// master = pin/board side driving raw_i, slave = the conditioner.
interface gpio_input_conditioner_if #(
    parameter int W = 22
);
    logic [W-1:0] raw_i;
    logic [W-1:0] gpio_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         tick_o;

    modport master (output raw_i, input gpio_o, input rise_o, input fall_o, input tick_o);
    modport slave  (input raw_i, output gpio_o, output rise_o, output fall_o, output tick_o);
endinterface

// File: rtl/gpio_input_conditioner.sv
// Purpose: per-bit polarity fix, 2-FF sync and tick-based debounce of board inputs into SoC GPIO.
// Latency: 2 sync cycles + (STABLE_TICKS-1..STABLE_TICKS) tick windows + 1 cycle, prescaler-phase dependent.
// Backpressure: none; inputs are sampled every cycle and outputs are free-running levels/strobes.
module gpio_input_conditioner #(
    parameter int             W            = 22,
    parameter int             TICK_CYCLES  = 50000,
    parameter int             STABLE_TICKS = 10,
    parameter logic [W-1:0]   INVERT_MASK  = W'(22'h3C0000)
) (
    input  logic                     clk,
    input  logic                     reset,
    gpio_input_conditioner_if.slave  bus
);
    localparam int             PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int             CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0]  PMAX = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0]  CMAX = CW'(STABLE_TICKS - 1);

    typedef enum logic {ST_STABLE, ST_PEND} state_t;

    logic [W-1:0]  inv;
    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  gpio_q;
    logic [W-1:0]  rise_q;
    logic [W-1:0]  fall_q;
    logic          tick_q;
    logic [PW-1:0] pcnt;
    state_t        state [W];
    logic [CW-1:0] cnt   [W];

    // Inversion sits ahead of the synchronizer so s1 is the only flop seeing async data.
    assign inv = bus.raw_i ^ INVERT_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= inv;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pcnt == PMAX);
            pcnt   <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < W; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < W; i++) begin
                case (state[i])
                    ST_STABLE: begin
                        cnt[i] <= '0;
                        if (s2[i] != gpio_q[i]) begin
                            state[i] <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        // Any return to the accepted level, however brief, restarts the window.
                        if (s2[i] == gpio_q[i]) begin
                            cnt[i]   <= '0;
                            state[i] <= ST_STABLE;
                        end else if (tick_q) begin
                            if (cnt[i] == CMAX) begin
                                gpio_q[i] <= s2[i];
                                rise_q[i] <= s2[i];
                                fall_q[i] <= ~s2[i];
                                cnt[i]    <= '0;
                                state[i]  <= ST_STABLE;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        cnt[i]   <= '0;
                        state[i] <= ST_STABLE;
                    end
                endcase
            end
        end
    end

    assign bus.gpio_o = gpio_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;
    assign bus.tick_o = tick_q;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed plus randomized bench for gpio_input_conditioner against a cycle-level reference model.
module tb_gpio_input_conditioner;
    localparam int           W    = 4;
    localparam int           TC   = 4;
    localparam int           ST   = 3;
    localparam logic [W-1:0] MASK = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpio_input_conditioner_if #(.W(W)) bus ();

    gpio_input_conditioner #(
        .W            (W),
        .TICK_CYCLES  (TC),
        .STABLE_TICKS (ST),
        .INVERT_MASK  (MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: sync delay line, cycle index since reset, and per-bit mismatch runs.
    logic [W-1:0] q1 = '0, q2 = '0, mg = '0, mr = '0, mf = '0;
    logic         mt = 1'b0;
    int           k  = 0;
    bit           inrun [W];
    int           tc    [W];

    int n, cnt_a, cnt_b, bad, ticks, joint;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] ng;
        if (reset) begin
            q1 = '0; q2 = '0; mg = '0; mr = '0; mf = '0; mt = 1'b0; k = 0;
            for (int i = 0; i < W; i++) begin
                inrun[i] = 1'b0;
                tc[i]    = 0;
            end
        end else begin
            ng = mg; mr = '0; mf = '0;
            for (int i = 0; i < W; i++) begin
                if (q2[i] != mg[i]) begin
                    if (!inrun[i]) begin
                        inrun[i] = 1'b1;
                        tc[i]    = 0;
                    end else if (mt) begin
                        tc[i]++;
                        if (tc[i] == ST) begin
                            ng[i]    = q2[i];
                            mr[i]    = q2[i];
                            mf[i]    = ~q2[i];
                            inrun[i] = 1'b0;
                        end
                    end
                end else begin
                    inrun[i] = 1'b0;
                end
            end
            mg = ng;
            q2 = q1;
            q1 = bus.raw_i ^ MASK;
            k++;
            mt = ((k % TC) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gpio", 32'(bus.gpio_o), 32'(mg));
        check("rise", 32'(bus.rise_o), 32'(mr));
        check("fall", 32'(bus.fall_o), 32'(mf));
        check("tick", 32'(bus.tick_o), 32'(mt));
    endtask

    initial begin
        reset = 1'b1;
        bus.raw_i = 4'b1000;
        step();
        step();
        reset = 1'b0;

        // Idle with KEY released: nothing moves, tick every 4th cycle.
        ticks = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.tick_o) ticks++;
            if ((|bus.gpio_o) || (|bus.rise_o) || (|bus.fall_o)) bad++;
        end
        check("t1_tick_count", 32'(ticks), 32'd25);
        check("t1_quiet", 32'(bad), 32'd0);

        // Single switch change: acceptance window and single rise strobe.
        bus.raw_i = 4'b1001;
        n = 0; cnt_a = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (n == 0 && bus.gpio_o[0]) n = c;
            if (bus.rise_o[0]) cnt_a++;
        end
        check("t2_latency_window", 32'(n >= 11 && n <= 15), 32'd1);
        check("t2_rise_pulses", 32'(cnt_a), 32'd1);

        // Bouncing input shorter than the stable window never gets through.
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 6 == 0) bus.raw_i[1] = ~bus.raw_i[1];
            step();
            if (bus.gpio_o[1]) bad++;
        end
        check("t3_bounce_rejected", 32'(bad), 32'd0);

        // Active-low KEY press then release.
        bus.raw_i[3] = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rise_o[3]) cnt_a++;
        end
        check("t4_press_level", 32'(bus.gpio_o[3]), 32'd1);
        check("t4_press_rise", 32'(cnt_a), 32'd1);
        bus.raw_i[3] = 1'b1;
        cnt_b = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.fall_o[3]) cnt_b++;
        end
        check("t4_release_level", 32'(bus.gpio_o[3]), 32'd0);
        check("t4_release_fall", 32'(cnt_b), 32'd1);

        // Three bits changing together land in the same cycle.
        bus.raw_i = 4'b1000;
        for (int c = 0; c < 20; c++) step();
        check("t5_settled", 32'(bus.gpio_o), 32'd0);
        bus.raw_i = 4'b1111;
        joint = 0; cnt_a = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rise_o[2:0] == 3'b111) joint++;
            cnt_a += int'(bus.rise_o[0]) + int'(bus.rise_o[1]) + int'(bus.rise_o[2]);
        end
        check("t5_joint_rise", 32'(joint), 32'd1);
        check("t5_total_rise", 32'(cnt_a), 32'd3);
        check("t5_level", 32'(bus.gpio_o), 32'd7);

        // Reset mid-debounce discards the pending change; window restarts from scratch.
        bus.raw_i = 4'b1000;
        for (int c = 0; c < 20; c++) step();
        bus.raw_i = 4'b1001;
        for (int c = 0; c < 8; c++) step();
        check("t6_pre_reset", 32'(bus.gpio_o[0]), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (n == 0 && bus.gpio_o[0]) n = c;
        end
        check("t6_restart_latency", 32'(n), 32'd13);

        // Randomized segments with occasional resets, all checked against the model.
        for (int seg = 0; seg < 60; seg++) begin
            bus.raw_i = W'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            for (int c = 0; c < int'($urandom_range(1, 18)); c++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
